led_strand_driver: RTL and testbench

Downstream consumer of the pattern generators. Walks LED indices 0..NUM_LEDS-1 on next_led_request and captures each returned colour when color_valid is high. Serialises each colour as a WS2812-style single-wire stream: GRB order, MSB first, pulse-width-coded bits. Ends each frame with a low latch period, then idles or refreshes again.

---
 rtl/led_pkg.sv | 42 ++++
 rtl/led_strand_driver_if.sv | 33 +++
 rtl/led_bit_encoder.sv | 74 +++++++
 rtl/led_strand_driver.sv | 143 ++++++++++++++
 tb/tb_led_strand_driver.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types, default timings and sizing helpers for the LED strand driver.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BIT_HIGH,
    BIT_LOW,
    LATCH
  } led_state_e;

  localparam int DEFAULT_NUM_LEDS     = 20;
  localparam int DEFAULT_COLOR_WIDTH  = 8;
  localparam int DEFAULT_T0H_CYCLES   = 40;
  localparam int DEFAULT_T0L_CYCLES   = 85;
  localparam int DEFAULT_T1H_CYCLES   = 80;
  localparam int DEFAULT_T1L_CYCLES   = 45;
  localparam int DEFAULT_LATCH_CYCLES = 8000;

  // One LED frame carries green, red and blue back to back.
  function automatic int bits_per_led(input int color_width);
    return 3 * color_width;
  endfunction

  // LED index width, never narrower than one bit.
  function automatic int index_width(input int num_leds);
    return (num_leds > 1) ? $clog2(num_leds) : 1;
  endfunction

  // Timer width large enough for the longest phase, with one bit of headroom.
  function automatic int timer_width(input int t0h, input int t0l, input int t1h,
                                     input int t1l, input int latch);
    int m;
    m = t0h;
    if (t0l > m) m = t0l;
    if (t1h > m) m = t1h;
    if (t1l > m) m = t1l;
    if (latch > m) m = latch;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/led_strand_driver_if.sv
// Pixel fetch handshake between the strand driver and a pattern generator.
interface led_strand_driver_if
  import led_pkg::*;
#(
  parameter int NUM_LEDS    = DEFAULT_NUM_LEDS,
  parameter int COLOR_WIDTH = DEFAULT_COLOR_WIDTH
) ();

  localparam int CounterWidth = index_width(NUM_LEDS);

  logic [CounterWidth-1:0] next_led_request;
  logic [COLOR_WIDTH-1:0]  red_in;
  logic [COLOR_WIDTH-1:0]  green_in;
  logic [COLOR_WIDTH-1:0]  blue_in;
  logic                    color_valid_in;

  modport master (
    output next_led_request,
    input  red_in,
    input  green_in,
    input  blue_in,
    input  color_valid_in
  );

  modport slave (
    input  next_led_request,
    output red_in,
    output green_in,
    output blue_in,
    output color_valid_in
  );

endinterface

// File: rtl/led_bit_encoder.sv
// Produces one pulse-width-coded bit: a high phase then a low phase, each timed exactly.
module led_bit_encoder
  import led_pkg::*;
#(
  parameter int T0H_CYCLES  = DEFAULT_T0H_CYCLES,
  parameter int T0L_CYCLES  = DEFAULT_T0L_CYCLES,
  parameter int T1H_CYCLES  = DEFAULT_T1H_CYCLES,
  parameter int T1L_CYCLES  = DEFAULT_T1L_CYCLES,
  parameter int TIMER_WIDTH = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic start,
  input  logic bit_value,
  output logic line,
  output logic done
);

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_HIGH,
    PH_LOW
  } phase_e;

  localparam logic [TIMER_WIDTH-1:0] T0hLoad = TIMER_WIDTH'(T0H_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] T0lLoad = TIMER_WIDTH'(T0L_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] T1hLoad = TIMER_WIDTH'(T1H_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] T1lLoad = TIMER_WIDTH'(T1L_CYCLES - 1);

  phase_e                 phase;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   bit_q;

  // done marks the last cycle of whichever phase is running
  assign done = (phase != PH_IDLE) && (timer == '0);

  // Phase sequencing and countdown; a start on the final low cycle chains bits without a gap
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phase <= PH_IDLE;
      timer <= '0;
      bit_q <= 1'b0;
      line  <= 1'b0;
    end else if (start) begin
      phase <= PH_HIGH;
      bit_q <= bit_value;
      timer <= bit_value ? T1hLoad : T0hLoad;
      line  <= 1'b1;
    end else begin
      case (phase)
        PH_HIGH: begin
          if (timer == '0) begin
            phase <= PH_LOW;
            timer <= bit_q ? T1lLoad : T0lLoad;
            line  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        PH_LOW: begin
          if (timer == '0) begin
            phase <= PH_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          line <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_strand_driver.sv
// Fetches colours LED by LED and streams them GRB, MSB first, onto a WS2812-style line.
module led_strand_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = DEFAULT_NUM_LEDS,
  parameter int COLOR_WIDTH  = DEFAULT_COLOR_WIDTH,
  parameter int T0H_CYCLES   = DEFAULT_T0H_CYCLES,
  parameter int T0L_CYCLES   = DEFAULT_T0L_CYCLES,
  parameter int T1H_CYCLES   = DEFAULT_T1H_CYCLES,
  parameter int T1L_CYCLES   = DEFAULT_T1L_CYCLES,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       enable_in,
  led_strand_driver_if.master        pix,
  output logic                       strand_out,
  output logic                       busy_out,
  output logic                       frame_done_out
);

  localparam int CounterWidth  = index_width(NUM_LEDS);
  localparam int BitsPerLed    = bits_per_led(COLOR_WIDTH);
  localparam int BitCountWidth = $clog2(BitsPerLed + 1);
  localparam int TimerWidth    = timer_width(T0H_CYCLES, T0L_CYCLES, T1H_CYCLES,
                                             T1L_CYCLES, LATCH_CYCLES);

  localparam logic [CounterWidth-1:0]  LastLed   = CounterWidth'(NUM_LEDS - 1);
  localparam logic [BitCountWidth-1:0] BitsLoad  = BitCountWidth'(BitsPerLed);
  localparam logic [BitCountWidth-1:0] LastBit   = BitCountWidth'(1);
  localparam logic [TimerWidth-1:0]    LatchLoad = TimerWidth'(LATCH_CYCLES - 1);

  led_state_e              state;
  led_state_e              next_state;
  logic [BitsPerLed-1:0]   shift_reg;
  logic [BitCountWidth-1:0] bit_count;
  logic [CounterWidth-1:0] led_index;
  logic [TimerWidth-1:0]   latch_timer;
  logic                    fetch_armed;

  logic capture;
  logic bit_end;
  logic more_bits;
  logic more_leds;
  logic latch_end;
  logic enc_start;
  logic enc_bit;
  logic enc_done;

  assign pix.next_led_request = led_index;

  led_bit_encoder #(
    .T0H_CYCLES (T0H_CYCLES),
    .T0L_CYCLES (T0L_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .T1L_CYCLES (T1L_CYCLES),
    .TIMER_WIDTH(TimerWidth)
  ) u_encoder (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (enc_start),
    .bit_value(enc_bit),
    .line     (strand_out),
    .done     (enc_done)
  );

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decision; FETCH has no timeout and waits for valid data
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (enable_in) next_state = FETCH;
      FETCH:    if (capture) next_state = BIT_HIGH;
      BIT_HIGH: if (enc_done) next_state = BIT_LOW;
      BIT_LOW: begin
        if (bit_end) begin
          if (more_bits) next_state = BIT_HIGH;
          else if (more_leds) next_state = FETCH;
          else next_state = LATCH;
        end
      end
      LATCH:    if (latch_end) next_state = enable_in ? FETCH : IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Per-state decode; the first FETCH cycle is skipped because the generator index is stale
  always_comb begin
    capture   = (state == FETCH) && fetch_armed && pix.color_valid_in;
    bit_end   = (state == BIT_LOW) && enc_done;
    more_bits = (bit_count != LastBit);
    more_leds = (led_index < LastLed);
    latch_end = (state == LATCH) && (latch_timer == '0);
    enc_start = capture || (bit_end && more_bits);
    enc_bit   = capture ? pix.green_in[COLOR_WIDTH-1] : shift_reg[BitsPerLed-2];
  end

  // Datapath: shift register, bit and LED counters, latch timer and registered status outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_reg      <= '0;
      bit_count      <= '0;
      led_index      <= '0;
      latch_timer    <= '0;
      fetch_armed    <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      fetch_armed    <= (state == FETCH) && (next_state == FETCH);
      busy_out       <= (next_state != IDLE);
      frame_done_out <= latch_end;

      if (((state == IDLE) || latch_end) && enable_in) begin
        led_index <= '0;
      end else if (bit_end && !more_bits && more_leds) begin
        led_index <= led_index + 1'b1;
      end

      if (capture) begin
        shift_reg <= {pix.green_in, pix.red_in, pix.blue_in};
        bit_count <= BitsLoad;
      end else if (bit_end) begin
        shift_reg <= {shift_reg[BitsPerLed-2:0], 1'b0};
        bit_count <= bit_count - 1'b1;
      end

      if (bit_end && !more_bits && !more_leds) begin
        latch_timer <= LatchLoad;
      end else if ((state == LATCH) && (latch_timer != '0)) begin
        latch_timer <= latch_timer - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_strand_driver.sv
// Directed bench: two strands (2 and 3 LEDs) with a pattern-generator model and a pulse decoder scoreboard.
module tb_led_strand_driver;
  import led_pkg::*;

  localparam int ColorWidth = 8;
  localparam int T0h        = 2;
  localparam int T0l        = 4;
  localparam int T1h        = 4;
  localparam int T1l        = 2;
  localparam int LatchC     = 10;

  logic clk = 1'b0;
  logic rst;
  logic enable [2];
  int   mode;

  logic [23:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  logic strand_o [2];
  logic busy_o [2];
  logic fd_o [2];
  int   req_o [2];
  int   fd_count_o [2];
  int   pulse_count_o [2];
  int   max_req_o [2];

  int base_p;
  int base_fd;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // GRB word the generator model presents for a given LED index
  function automatic logic [23:0] colorOf(input int m, input int idx);
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    if (m == 0) return 24'hFF0001;
    g = 8'hA5 ^ 8'(idx * 31);
    r = 8'(60 + idx * 17);
    b = 8'(1 + idx * 82);
    return {g, r, b};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int NumLeds = (g == 0) ? 2 : 3;

    led_strand_driver_if #(.NUM_LEDS(NumLeds), .COLOR_WIDTH(ColorWidth)) pix ();

    logic        strand;
    logic        busy;
    logic        fdone;
    logic        valid;
    logic [23:0] color;
    logic [23:0] word;
    logic        last_bit;
    int last_req, age, hi_len, low_run, nbits, fd_count, pulse_count, max_req;

    led_strand_driver #(
      .NUM_LEDS    (NumLeds),
      .COLOR_WIDTH (ColorWidth),
      .T0H_CYCLES  (T0h),
      .T0L_CYCLES  (T0l),
      .T1H_CYCLES  (T1h),
      .T1L_CYCLES  (T1l),
      .LATCH_CYCLES(LatchC)
    ) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .enable_in     (enable[g]),
      .pix           (pix),
      .strand_out    (strand),
      .busy_out      (busy),
      .frame_done_out(fdone)
    );

    // Generator model: registers the requested index, colours follow one cycle later
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        last_req <= 0;
        age      <= 0;
      end else begin
        last_req <= int'(pix.next_led_request);
        age      <= (int'(pix.next_led_request) != last_req) ? 0 : ((age < 1000) ? age + 1 : age);
      end
    end

    always_comb begin
      valid = (int'(pix.next_led_request) == last_req);
      if (mode == 2) valid = valid && (age >= ((last_req == 1) ? 7 : 0));
      if (mode == 3) valid = 1'b1;
      color = (mode == 2 && !valid) ? 24'h5A5A5A : colorOf(mode, last_req);
    end

    assign pix.green_in       = color[23:16];
    assign pix.red_in         = color[15:8];
    assign pix.blue_in        = color[7:0];
    assign pix.color_valid_in = valid;

    assign strand_o[g]      = strand;
    assign busy_o[g]        = busy;
    assign fd_o[g]          = fdone;
    assign req_o[g]         = int'(pix.next_led_request);
    assign fd_count_o[g]    = fd_count;
    assign pulse_count_o[g] = pulse_count;
    assign max_req_o[g]     = max_req;

    // Line decoder: classifies high widths into bits, pops expected words, checks latch low time
    initial begin
      hi_len = 0; low_run = 0; nbits = 0; word = '0; last_bit = 1'b0;
      fd_count = 0; pulse_count = 0; max_req = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          hi_len = 0; low_run = 0; nbits = 0;
        end else begin
          if (int'(pix.next_led_request) > max_req) max_req = int'(pix.next_led_request);
          if (strand) begin
            hi_len++;
            low_run = 0;
          end else begin
            low_run++;
            if (hi_len != 0) begin
              checkOutput("pulse_width", 32'(hi_len == T0h || hi_len == T1h), 32'd1);
              last_bit = (hi_len == T1h);
              word = {word[22:0], last_bit};
              pulse_count++;
              nbits++;
              hi_len = 0;
              if (nbits == 24) begin
                nbits = 0;
                checkOutput("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) checkOutput("led_word", 32'(word), 32'(exp_q.pop_front()));
              end
            end
            if (fdone) begin
              fd_count++;
              checkOutput("latch_low", 32'(low_run), 32'((last_bit ? T1l : T0l) + LatchC + 1));
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int ln, input int m, input int leds, input int frames, input bit hold);
    mode = m;
    for (int f = 0; f < frames; f++)
      for (int i = 0; i < leds; i++) exp_q.push_back(colorOf(m, i));
    @(negedge clk);
    enable[ln] = 1'b1;
    if (!hold) begin
      @(negedge clk);
      enable[ln] = 1'b0;
    end
  endtask

  task automatic waitFrame(input int ln, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fd_o[ln]) return;
    end
    checkOutput("frame_timeout", 32'(fd_o[ln]), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    enable[0] = 1'b0;
    enable[1] = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput("reset_strand", 32'(strand_o[g]), 32'd0);
      checkOutput("reset_busy", 32'(busy_o[g]), 32'd0);
      checkOutput("reset_frame_done", 32'(fd_o[g]), 32'd0);
      checkOutput("reset_request", 32'(req_o[g]), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fixed colour, single enable pulse
    $display("[TB] fixed colour frame");
    base_p  = pulse_count_o[0];
    base_fd = fd_count_o[0];
    applyStimulus(0, 0, 2, 1, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("t1_busy_running", 32'(busy_o[0]), 32'd1);
    waitFrame(0, 2000);
    @(negedge clk);
    checkOutput("t1_pulses", 32'(pulse_count_o[0] - base_p), 32'd48);
    checkOutput("t1_frame_done", 32'(fd_count_o[0] - base_fd), 32'd1);
    checkOutput("t1_busy_idle", 32'(busy_o[0]), 32'd0);
    checkOutput("t1_frame_done_pulse", 32'(fd_o[0]), 32'd0);
    checkOutput("t1_queue", 32'(exp_q.size()), 32'd0);

    // Continuous refresh over three frames, enable dropped during the third
    $display("[TB] request walk");
    base_fd = fd_count_o[0];
    applyStimulus(0, 1, 2, 3, 1'b1);
    waitFrame(0, 2000);
    waitFrame(0, 2000);
    enable[0] = 1'b0;
    waitFrame(0, 2000);
    repeat (3) @(negedge clk);
    checkOutput("t2_frame_done", 32'(fd_count_o[0] - base_fd), 32'd3);
    checkOutput("t2_busy_idle", 32'(busy_o[0]), 32'd0);
    checkOutput("t2_queue", 32'(exp_q.size()), 32'd0);
    checkOutput("t2_max_request", 32'(max_req_o[0]), 32'd1);

    // Delayed valid on LED 1 with junk colours until valid
    $display("[TB] delayed valid");
    applyStimulus(0, 2, 2, 1, 1'b0);
    waitFrame(0, 2000);
    @(negedge clk);
    checkOutput("t3_queue", 32'(exp_q.size()), 32'd0);

    // Valid held high; first FETCH cycle presents the previous LED's colour
    $display("[TB] stale valid");
    applyStimulus(0, 3, 2, 1, 1'b0);
    waitFrame(0, 2000);
    @(negedge clk);
    checkOutput("t4_queue", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a high pulse
    $display("[TB] reset mid-bit");
    applyStimulus(0, 0, 2, 1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (strand_o[0]) break;
      @(negedge clk);
    end
    checkOutput("t5_strand_high_seen", 32'(strand_o[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_async_strand", 32'(strand_o[0]), 32'd0);
    checkOutput("t5_async_busy", 32'(busy_o[0]), 32'd0);
    checkOutput("t5_async_request", 32'(req_o[0]), 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t5_idle_strand", 32'(strand_o[0]), 32'd0);
      checkOutput("t5_idle_busy", 32'(busy_o[0]), 32'd0);
    end
    checkOutput("t5_idle_request", 32'(req_o[0]), 32'd0);

    // Three-LED strand
    $display("[TB] odd LED count");
    base_p  = pulse_count_o[1];
    base_fd = fd_count_o[1];
    applyStimulus(1, 1, 3, 1, 1'b0);
    waitFrame(1, 3000);
    @(negedge clk);
    checkOutput("t6_pulses", 32'(pulse_count_o[1] - base_p), 32'd72);
    checkOutput("t6_frame_done", 32'(fd_count_o[1] - base_fd), 32'd1);
    checkOutput("t6_max_request", 32'(max_req_o[1]), 32'd2);
    checkOutput("t6_busy_idle", 32'(busy_o[1]), 32'd0);
    checkOutput("t6_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
